// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: one-outstanding instruction fetch feeding a DEPTH-entry prefetch FIFO
// towards decode, with redirect support that squashes queued and in-flight work.
module fetch_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [ILEN-1:0]            imem_rsp_data,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [ILEN-1:0]            id_instr,
    output logic [XLEN-1:0]            id_pc,
    output logic [XLEN-1:0]            id_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0] fill_count,
    output logic [1:0]                 dbg_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // the sender keeps its payload stable until then, except a redirect may withdraw a request.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc_f;
    logic [XLEN-1:0]   r_inflight_pc;

    logic [ILEN-1:0]   r_instr_mem [DEPTH];
    logic [XLEN-1:0]   r_pc_mem    [DEPTH];
    logic [XLEN-1:0]   r_pc4_mem   [DEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;

    logic              w_outstanding;
    logic              w_space;
    logic              w_req_valid;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_head_valid;

    // An accepted request reserves a slot until its response arrives, so a push never overflows.
    assign w_outstanding = (r_state == S_WAIT);
    assign w_space       = ({1'b0, r_count} + {{CW{1'b0}}, w_outstanding}) < (CW+1)'(DEPTH);
    assign w_req_valid   = (r_state == S_REQ) && w_space;
    assign w_accept      = w_req_valid && imem_req_ready;
    assign w_head_valid  = (r_count != '0);
    assign w_push        = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;
    assign w_pop         = w_head_valid && id_ready && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_REQ;
            r_pc_f        <= RESET_PC;
            r_inflight_pc <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_accept) begin
                        r_inflight_pc <= r_pc_f;
                        r_state       <= redirect_valid ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_state <= S_REQ;
                    end else if (redirect_valid) begin
                        r_state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase

            if (redirect_valid) begin
                r_pc_f <= redirect_pc;
            end else if (w_accept) begin
                r_pc_f <= r_pc_f + XLEN'(4);
            end
        end
    end

    // The FIFO stores PC+4 alongside each entry so decode never recomputes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr_mem[i] <= '0;
                r_pc_mem[i]    <= '0;
                r_pc4_mem[i]   <= '0;
            end
        end else if (redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_instr_mem[r_wr_ptr] <= imem_rsp_data;
                r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
                r_pc4_mem[r_wr_ptr]   <= r_inflight_pc + XLEN'(4);
                r_wr_ptr              <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc_f;
    assign id_valid       = w_head_valid;
    assign id_instr       = w_head_valid ? r_instr_mem[r_rd_ptr] : '0;
    assign id_pc          = w_head_valid ? r_pc_mem[r_rd_ptr]    : '0;
    assign id_pc_plus4    = w_head_valid ? r_pc4_mem[r_rd_ptr]   : '0;
    assign fill_count     = r_count;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: ordering, backpressure, redirects, wrap, reset.
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [2:0]  fill_count;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  fetch_prefetch_queue #(
    .XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .fill_count(fill_count), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one fetch with a one-cycle response
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data);
    imem_req_ready = 1'b1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_addr) begin
      n_err++;
      $display("FAIL fetch_req: valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, exp_addr);
    end
    tick();
    imem_req_ready = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b0 || dbg_state !== 2'd1) begin
      n_err++;
      $display("FAIL fetch_wait: valid=%b state=%0d, required valid=0 state=1", imem_req_valid, dbg_state);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    id_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_req: valid=%b addr=%h, required valid=1 addr=0", imem_req_valid, imem_req_addr);
    end
    n_cmp++;
    if (id_valid !== 1'b0 || fill_count !== 3'd0) begin
      n_err++;
      $display("FAIL reset_fifo: id_valid=%b fill=%0d, required 0/0", id_valid, fill_count);
    end
    n_cmp++;
    if (id_instr !== 32'h0 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin
      n_err++;
      $display("FAIL reset_id: instr=%h pc=%h pc4=%h, required all 0", id_instr, id_pc, id_pc_plus4);
    end
  endtask

  task automatic test_in_order();
    logic [31:0] a_pc[3];
    logic [31:0] a_in[3];
    a_pc[0] = 32'h0; a_pc[1] = 32'h4; a_pc[2] = 32'h8;
    a_in[0] = 32'hAAAA0001; a_in[1] = 32'hBBBB0002; a_in[2] = 32'hCCCC0003;
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_fetch(a_pc[i], a_in[i]);
      n_cmp++;
      if (id_valid !== 1'b1 || id_pc !== a_pc[i] || id_instr !== a_in[i] || id_pc_plus4 !== a_pc[i] + 32'h4) begin
        n_err++;
        $display("FAIL in_order[%0d]: v=%b pc=%h in=%h pc4=%h, required v=1 pc=%h in=%h pc4=%h",
                 i, id_valid, id_pc, id_instr, id_pc_plus4, a_pc[i], a_in[i], a_pc[i] + 32'h4);
      end
      n_cmp++;
      if (fill_count !== 3'd1) begin
        n_err++;
        $display("FAIL in_order_fill[%0d]: fill=%0d, required 1", i, fill_count);
      end
    end
    tick();
    id_ready = 1'b0;
    n_cmp++;
    if (id_valid !== 1'b0 || fill_count !== 3'd0 || imem_req_addr !== 32'hC) begin
      n_err++;
      $display("FAIL in_order_drain: v=%b fill=%0d addr=%h, required 0/0/0000000c", id_valid, fill_count, imem_req_addr);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] b_pc[4];
    logic [31:0] b_in[4];
    for (int i = 0; i < 4; i++) begin
      b_pc[i] = 32'hC + 32'(i * 4);
      b_in[i] = 32'hD0D0_0000 + 32'(i);
    end
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_fetch(b_pc[i], b_in[i]);
    n_cmp++;
    if (fill_count !== 3'd4 || imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL full: fill=%0d req_valid=%b, required 4/0", fill_count, imem_req_valid);
    end
    imem_req_ready = 1'b1;
    repeat (2) tick();
    imem_req_ready = 1'b0;
    n_cmp++;
    if (fill_count !== 3'd4 || imem_req_valid !== 1'b0 || id_pc !== 32'hC || id_instr !== b_in[0]) begin
      n_err++;
      $display("FAIL stall_hold: fill=%0d rv=%b pc=%h in=%h, required 4/0/0000000c/%h", fill_count, imem_req_valid, id_pc, id_instr, b_in[0]);
    end
    id_ready = 1'b1;
    tick();
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1C || fill_count !== 3'd3) begin
      n_err++;
      $display("FAIL resume_req: rv=%b addr=%h fill=%0d, required 1/0000001c/3", imem_req_valid, imem_req_addr, fill_count);
    end
    for (int i = 1; i < 4; i++) begin
      n_cmp++;
      if (id_valid !== 1'b1 || id_pc !== b_pc[i] || id_instr !== b_in[i] || id_pc_plus4 !== b_pc[i] + 32'h4) begin
        n_err++;
        $display("FAIL drain[%0d]: v=%b pc=%h in=%h pc4=%h, required pc=%h in=%h", i, id_valid, id_pc, id_instr, id_pc_plus4, b_pc[i], b_in[i]);
      end
      tick();
    end
    id_ready = 1'b0;
    n_cmp++;
    if (id_valid !== 1'b0 || fill_count !== 3'd0) begin
      n_err++;
      $display("FAIL drain_empty: v=%b fill=%0d, required 0/0", id_valid, fill_count);
    end
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (dbg_state !== 2'd2 || imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redir_wait_drop: state=%0d rv=%b, required 2/0", dbg_state, imem_req_valid);
    end
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF;
    tick();
    imem_rsp_valid = 1'b0;
    n_cmp++;
    if (fill_count !== 3'd0 || id_valid !== 1'b0 || imem_req_addr !== 32'h100 || imem_req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL redir_late_rsp: fill=%0d v=%b addr=%h rv=%b, required 0/0/00000100/1", fill_count, id_valid, imem_req_addr, imem_req_valid);
    end
    do_fetch(32'h100, 32'h11111111);
    n_cmp++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'h11111111 || id_pc_plus4 !== 32'h104) begin
      n_err++;
      $display("FAIL redir_first: v=%b pc=%h in=%h pc4=%h, required 1/00000100/11111111/00000104", id_valid, id_pc, id_instr, id_pc_plus4);
    end
  endtask

  task automatic test_redirect_push_pop();
    do_fetch(32'h104, 32'h22222222);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    n_cmp++;
    if (fill_count !== 3'd2 || dbg_state !== 2'd1) begin
      n_err++;
      $display("FAIL pp_setup: fill=%0d state=%0d, required 2/1", fill_count, dbg_state);
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h33333333;
    id_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    imem_rsp_valid = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
    n_cmp++;
    if (fill_count !== 3'd0 || id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL pp_flush: fill=%0d v=%b, required 0/0", fill_count, id_valid);
    end
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL pp_req: rv=%b addr=%h state=%0d, required 1/00000200/0", imem_req_valid, imem_req_addr, dbg_state);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFFFFFC || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL req_withdraw: rv=%b addr=%h state=%0d, required 1/fffffffc/0", imem_req_valid, imem_req_addr, dbg_state);
    end
    do_fetch(32'hFFFFFFFC, 32'h44444444);
    n_cmp++;
    if (id_pc !== 32'hFFFFFFFC || id_pc_plus4 !== 32'h0 || id_instr !== 32'h44444444) begin
      n_err++;
      $display("FAIL wrap_entry: pc=%h pc4=%h in=%h, required fffffffc/00000000/44444444", id_pc, id_pc_plus4, id_instr);
    end
    n_cmp++;
    if (imem_req_addr !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_pcf: addr=%h, required 00000000", imem_req_addr);
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
  endtask

  task automatic test_redirect_accept();
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    imem_req_ready = 1'b0;
    n_cmp++;
    if (dbg_state !== 2'd2 || imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL accept_redir: state=%0d rv=%b, required 2/0", dbg_state, imem_req_valid);
    end
    redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (dbg_state !== 2'd2 || imem_req_addr !== 32'h400) begin
      n_err++;
      $display("FAIL drop_redir: state=%0d addr=%h, required 2/00000400", dbg_state, imem_req_addr);
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h77777777;
    tick();
    imem_rsp_valid = 1'b0;
    n_cmp++;
    if (dbg_state !== 2'd0 || fill_count !== 3'd0 || imem_req_addr !== 32'h400) begin
      n_err++;
      $display("FAIL drop_exit: state=%0d fill=%0d addr=%h, required 0/0/00000400", dbg_state, fill_count, imem_req_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (dbg_state !== 2'd0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || fill_count !== 3'd0) begin
      n_err++;
      $display("FAIL async_reset: state=%0d rv=%b addr=%h fill=%0d, required 0/1/0/0", dbg_state, imem_req_valid, imem_req_addr, fill_count);
    end
    tick();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h55555555;
    tick();
    imem_rsp_valid = 1'b0;
    n_cmp++;
    if (fill_count !== 3'd0 || id_valid !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL stray_rsp: fill=%0d v=%b state=%0d, required 0/0/0", fill_count, id_valid, dbg_state);
    end
    do_fetch(32'h0, 32'h66666666);
    n_cmp++;
    if (id_pc !== 32'h0 || id_instr !== 32'h66666666 || id_pc_plus4 !== 32'h4) begin
      n_err++;
      $display("FAIL post_reset_entry: pc=%h in=%h pc4=%h, required 0/66666666/4", id_pc, id_instr, id_pc_plus4);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_backpressure();
    test_redirect_wait();
    test_redirect_push_pop();
    test_wrap();
    test_redirect_accept();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
